// File: rtl/beep_pkg.sv
// Shared definitions for the beep blocks: state encoding, phase select and
// default ON/OFF phase lengths in time-base ticks.
package beep_pkg;

    localparam int unsigned BEEP_CNT_W     = 3;
    localparam int unsigned BEEP_NB_W      = 4;
    localparam int unsigned BEEP_ON_TICKS  = 3;
    localparam int unsigned BEEP_OFF_TICKS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } beep_state_e;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } beep_phase_e;

endpackage

// File: rtl/beep_seq_if.sv
// Request/status bundle between alarm/chime control and the beep sequencer.
//   tick   : one-clk 10 Hz time-base pulse
//   start  : one-clk request to begin a sequence
//   nbeeps : beep count, sampled when start is accepted
//   stop   : abort request (level or pulse)
//   buzz   : buzzer drive
//   busy   : sequence running
//   done   : one-clk pulse on normal completion
interface beep_seq_if #(
    parameter int unsigned NB_W = 4
);
    logic            tick;
    logic            start;
    logic [NB_W-1:0] nbeeps;
    logic            stop;
    logic            buzz;
    logic            busy;
    logic            done;

    modport master (
        output tick, start, nbeeps, stop,
        input  buzz, busy, done
    );

    modport slave (
        input  tick, start, nbeeps, stop,
        output buzz, busy, done
    );
endinterface

// File: rtl/beep_phase_timer.sv
// Loadable phase down-counter for the beep sequencer.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : load the length selected by i_sel (priority over counting)
//   i_sel     : PH_ON loads ON_TICKS, PH_OFF loads OFF_TICKS
//   i_tick    : time-base pulse; decrements a non-zero count
//   i_clr     : force the count to zero (abort)
//   o_end_c   : combinational, tick seen while count==1 (phase ends)
module beep_phase_timer
    import beep_pkg::*;
#(
    parameter int unsigned CNT_W     = BEEP_CNT_W,
    parameter int unsigned ON_TICKS  = BEEP_ON_TICKS,
    parameter int unsigned OFF_TICKS = BEEP_OFF_TICKS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  beep_phase_e i_sel,
    input  logic        i_tick,
    input  logic        i_clr,
    output logic        o_end_c
);

    logic [CNT_W-1:0] r_cnt;

    // Count register; a load in the ending cycle starts the next phase cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_sel == PH_ON) ? CNT_W'(ON_TICKS) : CNT_W'(OFF_TICKS);
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_end_c = i_tick && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/beep_seq.sv
// Beep pattern sequencer: plays nbeeps ON phases separated by OFF phases.
//   clk, rst : clock, synchronous active-high reset (highest priority)
//   bus      : beep_seq_if slave (tick/start/nbeeps/stop in, buzz/busy/done out)
// Optional: define BEEP_TONE_EN to gate buzz with a TONE_DIV-clk square tone.
module beep_seq
    import beep_pkg::*;
#(
    parameter int unsigned CNT_W     = BEEP_CNT_W,
    parameter int unsigned ON_TICKS  = BEEP_ON_TICKS,
    parameter int unsigned OFF_TICKS = BEEP_OFF_TICKS,
    parameter int unsigned NB_W      = BEEP_NB_W,
    parameter int unsigned TONE_DIV  = 2500
) (
    input  logic        clk,
    input  logic        rst,
    beep_seq_if.slave   bus
);

    localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

    // Elaboration-time range check on the phase lengths.
    if ((ON_TICKS < 1) || (ON_TICKS > CNT_MAX)) begin : g_bad_on
        $error("beep_seq: ON_TICKS out of range 1..2^CNT_W-1");
    end
    if ((OFF_TICKS < 1) || (OFF_TICKS > CNT_MAX)) begin : g_bad_off
        $error("beep_seq: OFF_TICKS out of range 1..2^CNT_W-1");
    end
    if (TONE_DIV < 1) begin : g_bad_div
        $error("beep_seq: TONE_DIV must be at least 1");
    end

    beep_state_e     r_state, w_state_nxt;
    logic [NB_W-1:0] r_rem, w_rem_nxt;
    logic            w_load, w_clr, w_end, w_done_nxt, w_buzz_nxt;
    beep_phase_e     w_sel;
    logic            r_buzz, r_busy, r_done;

    beep_phase_timer #(
        .CNT_W     (CNT_W),
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_sel   (w_sel),
        .i_tick  (bus.tick),
        .i_clr   (w_clr),
        .o_end_c (w_end)
    );

    // State register plus registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_buzz  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_buzz  <= w_buzz_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and timer control.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_load      = 1'b0;
        w_sel       = PH_ON;
        w_clr       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // stop in the same cycle drops the start
                if (bus.start && !bus.stop && (bus.nbeeps != '0)) begin
                    w_state_nxt = ST_ON;
                    w_rem_nxt   = bus.nbeeps;
                    w_load      = 1'b1;
                    w_sel       = PH_ON;
                end
            end
            ST_ON: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                    w_clr       = 1'b1;
                end else if (w_end) begin
                    if (r_rem == NB_W'(1)) begin
                        // last beep: no trailing OFF phase
                        w_state_nxt = ST_IDLE;
                        w_rem_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_OFF;
                        w_rem_nxt   = r_rem - NB_W'(1);
                        w_load      = 1'b1;
                        w_sel       = PH_OFF;
                    end
                end
            end
            ST_OFF: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                    w_clr       = 1'b1;
                end else if (w_end) begin
                    w_state_nxt = ST_ON;
                    w_load      = 1'b1;
                    w_sel       = PH_ON;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rem_nxt   = '0;
                w_clr       = 1'b1;
            end
        endcase
    end

`ifdef BEEP_TONE_EN
    localparam int unsigned DIV_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic             r_tone, w_tone_nxt;

    // Divider held cleared outside ON so each beep starts with a low half-period.
    always_comb begin
        w_div_nxt  = '0;
        w_tone_nxt = 1'b0;
        if (r_state == ST_ON) begin
            if (r_div == DIV_W'(TONE_DIV - 1)) begin
                w_div_nxt  = '0;
                w_tone_nxt = ~r_tone;
            end else begin
                w_div_nxt  = r_div + DIV_W'(1);
                w_tone_nxt = r_tone;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_tone <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_tone <= w_tone_nxt;
        end
    end

    assign w_buzz_nxt = (w_state_nxt == ST_ON) && w_tone_nxt;
`else
    assign w_buzz_nxt = (w_state_nxt == ST_ON);
`endif

    assign bus.buzz = r_buzz;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
